// File: rtl/demux_comp.sv
// demux_comp -- registered 1-to-N demultiplexer with optional per-channel strobe counters.
//
// Routes the DATA_W-bit input d to output slice s. Every other slice drives zero.
// All outputs are registered, so they appear one clock after the inputs are sampled.
//
// Parameters:
//   DATA_W  width of d and of each output slice
//   SEL_W   select width; N_OUT = 2**SEL_W slices
//   CNT_W   width of each per-channel counter (used only with the counter block)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset (wins over en)
//   d        data to route
//   s        binary output select
//   en       route strobe
//   y        flattened outputs; slice i = y[i*DATA_W +: DATA_W]
//   y_valid  one-hot; bit i set = slice i was loaded on the last edge
//   cnt_sel  counter read select     (DEMUX_COMP_CNT_EN only)
//   cnt_out  counter[cnt_sel], comb  (DEMUX_COMP_CNT_EN only)
//
// Build option: define DEMUX_COMP_CNT_EN to add the saturating per-channel
// strobe counters and the cnt_sel/cnt_out ports.
module demux_comp #(
  parameter int DATA_W = 1,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               d,
  input  logic [SEL_W-1:0]                s,
  input  logic                            en,
  output logic [(2**SEL_W)*DATA_W-1:0]    y,
  output logic [(2**SEL_W)-1:0]           y_valid
`ifdef DEMUX_COMP_CNT_EN
  ,
  input  logic [SEL_W-1:0]                cnt_sel,
  output logic [CNT_W-1:0]                cnt_out
`endif
);

  localparam int N_OUT = 2**SEL_W;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("demux_comp: CNT_W must be at least 1");
  end

  logic [N_OUT-1:0]        sel_hit;
  logic [N_OUT*DATA_W-1:0] y_next;
  logic [N_OUT*DATA_W-1:0] y_reg;
  logic [N_OUT-1:0]        valid_reg;

  // Per-slice decode. A slice that is not hit loads zero, so data is never
  // left over from an earlier cycle.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slice
    assign sel_hit[gi] = en && (s == SEL_W'(gi));
    assign y_next[gi*DATA_W +: DATA_W] = sel_hit[gi] ? d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg     <= '0;
      valid_reg <= '0;
    end else begin
      y_reg     <= y_next;
      valid_reg <= sel_hit;
    end
  end

  assign y       = y_reg;
  assign y_valid = valid_reg;

`ifdef DEMUX_COMP_CNT_EN
  logic [CNT_W-1:0] cnt_reg [N_OUT];

  // Each channel counts its own strobes and sticks at all-ones.
  // Only rst clears a counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (sel_hit[i] && (cnt_reg[i] != {CNT_W{1'b1}}))
          cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
      end
    end
  end

  assign cnt_out = cnt_reg[cnt_sel];
`endif

endmodule

// File: tb/tb_demux_comp.sv
// tb_demux_comp -- self-checking bench for demux_comp (DATA_W=8, SEL_W=2, CNT_W=8).
// Directed cases come first, then a randomized run. Every result is checked
// against a behavioural model: expected y is d shifted into slice s, and each
// expected counter is a saturating integer.
module tb_demux_comp;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;
  localparam int N_OUT  = 4;
  localparam int CNT_MAX = 255;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [DATA_W-1:0]        d;
  logic [SEL_W-1:0]         s;
  logic                     en;
  logic [N_OUT*DATA_W-1:0]  y;
  logic [N_OUT-1:0]         y_valid;
`ifdef DEMUX_COMP_CNT_EN
  logic [SEL_W-1:0]         cnt_sel;
  logic [CNT_W-1:0]         cnt_out;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int cnt_model [N_OUT];

  demux_comp #(.DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .s       (s),
    .en      (en),
    .y       (y),
    .y_valid (y_valid)
`ifdef DEMUX_COMP_CNT_EN
    ,
    .cnt_sel (cnt_sel),
    .cnt_out (cnt_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Applies one set of inputs and lets one clock edge pass. It then checks
  // y and y_valid against the model. With the counter block built in, it
  // also reads back one counter.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [DATA_W-1:0] dd, input logic [SEL_W-1:0] ss);
    logic [N_OUT*DATA_W-1:0] exp_y;
    logic [N_OUT-1:0]        exp_v;
    rst = r; en = e; d = dd; s = ss;
    exp_y = '0;
    exp_v = '0;
    if (!r && e) begin
      exp_y = {{(N_OUT-1)*DATA_W{1'b0}}, dd} << (DATA_W * int'(ss));
      exp_v = N_OUT'(1) << int'(ss);
    end
    if (r) begin
      for (int i = 0; i < N_OUT; i++) cnt_model[i] = 0;
    end else if (e && cnt_model[ss] < CNT_MAX) begin
      cnt_model[ss]++;
    end
    @(posedge clk);
    #1;
    check({tag, " y"}, 64'(y), 64'(exp_y));
    check({tag, " y_valid"}, 64'(y_valid), 64'(exp_v));
    $display("%s: rst=%0b en=%0b s=%0d d=%02h -> y=%08h y_valid=%04b",
             tag, r, e, ss, dd, y, y_valid);
`ifdef DEMUX_COMP_CNT_EN
    cnt_sel = SEL_W'($urandom_range(0, N_OUT-1));
    #1;
    check({tag, " cnt_out"}, 64'(cnt_out), 64'(cnt_model[cnt_sel]));
`endif
  endtask

`ifdef DEMUX_COMP_CNT_EN
  task automatic read_cnt(input string tag, input int ch, input int exp);
    cnt_sel = SEL_W'(ch);
    #1;
    check(tag, 64'(cnt_out), 64'(exp));
    $display("%s: cnt_sel=%0d cnt_out=%0d", tag, ch, cnt_out);
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; d = '0; s = '0;
`ifdef DEMUX_COMP_CNT_EN
    cnt_sel = '0;
`endif
    for (int i = 0; i < N_OUT; i++) cnt_model[i] = 0;

    // Reset must win over en.
    step("reset0", 1'b1, 1'b1, 8'h01, 2'd0);
    step("reset1", 1'b1, 1'b1, 8'h01, 2'd1);

    // Walk the select across every slice.
    for (int i = 0; i < N_OUT; i++) step("walk", 1'b0, 1'b1, 8'h01, SEL_W'(i));

    // One routed beat, then idle clears the outputs.
    step("route_s2", 1'b0, 1'b1, 8'h01, 2'd2);
    step("idle_clear", 1'b0, 1'b0, 8'h01, 2'd2);

    // Zero data with a valid strobe.
    step("zero_data", 1'b0, 1'b1, 8'h00, 2'd1);

    // Full-width data on the top slice.
    step("a5_top", 1'b0, 1'b1, 8'hA5, 2'd3);

    // A reset mid-stream, then normal routing.
    step("mid_rst", 1'b1, 1'b1, 8'h3C, 2'd1);
    step("post_rst", 1'b0, 1'b1, 8'h3C, 2'd1);

`ifdef DEMUX_COMP_CNT_EN
    // Saturation test starts from cleared counters.
    step("cnt_clr", 1'b1, 1'b0, 8'h00, 2'd0);
    for (int i = 0; i < 300; i++) step("cnt_s1", 1'b0, 1'b1, 8'h11, 2'd1);
    for (int i = 0; i < 5; i++)   step("cnt_s2", 1'b0, 1'b1, 8'h22, 2'd2);
    step("cnt_idle", 1'b0, 1'b0, 8'h00, 2'd0);
    read_cnt("cnt_rd1", 1, 255);
    read_cnt("cnt_rd2", 2, 5);
    read_cnt("cnt_rd0", 0, 0);
    step("cnt_rst", 1'b1, 1'b0, 8'h00, 2'd0);
    for (int i = 0; i < N_OUT; i++) read_cnt("cnt_after_rst", i, 0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           DATA_W'($urandom), SEL_W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
